// File: rtl/axi_light_sram_bridge_if.sv
// AXI4-lite interface bundle (32-bit address/data, 4-bit strobe) used between
// the PiXo core's m_axi port and the SRAM bridge.
interface if_axi_light;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_light_sram_bridge.sv
// AXI4-lite slave to single-port synchronous byte-writable SRAM.
// One transaction outstanding at a time; write/read arbitration alternates
// when both are pending (write first after reset). Responses are held until
// the master takes them.
// Optional build macro AXI_SRAM_BRIDGE_RANGE_CHECK_EN: out-of-range accesses
// skip the SRAM, pulse err, and reads return 32'hDEAD_BEEF. Without it the
// word index simply wraps modulo MEM_WORDS and err is tied low.
module axi_light_sram_bridge #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned ADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              res_n,
  if_axi_light.slave        s_axi,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RWAIT, RDATA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              last_wr_q, last_wr_d;  // last served was a write -> read has priority
  logic              oor_q, oor_d;          // captured access is out of range

  logic              wr_pend, rd_pend, grant_wr, grant_rd;
  logic [31:0]       addr_sel;
  logic [32:0]       off;
  logic [ADDR_W-1:0] req_idx;
  logic              req_oor;
  logic              unused_bits;

  // A write needs both aw and w present; never accept one half alone.
  assign wr_pend  = s_axi.awvalid & s_axi.wvalid;
  assign rd_pend  = s_axi.arvalid;
  assign grant_wr = wr_pend & (~rd_pend | ~last_wr_q);
  assign grant_rd = rd_pend & ~grant_wr;

  // Offset kept 33 bits wide so an address below BASE_ADDR shows up as huge.
  assign addr_sel = grant_wr ? s_axi.awaddr : s_axi.araddr;
  assign off      = {1'b0, addr_sel} - {1'b0, BASE_ADDR};
  assign req_idx  = off[ADDR_W+1:2];

`ifdef AXI_SRAM_BRIDGE_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
  assign req_oor = (off >= SPAN);
  assign err     = res_n & (state_q == IDLE) & (grant_wr | grant_rd) & req_oor;
`else
  assign req_oor = 1'b0;
  assign err     = 1'b0;
`endif

  // Byte-lane bits, wrap bits and prot are intentionally not used.
  assign unused_bits = ^{off, s_axi.awprot, s_axi.arprot};

  assign s_axi.bresp = 2'b00;
  assign s_axi.rresp = 2'b00;
  assign s_axi.rdata = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  // Next-state, capture and handshake/SRAM strobes for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    last_wr_d     = last_wr_q;
    oor_d         = oor_q;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.rvalid  = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 4'h0;
    case (state_q)
      IDLE: begin
        // Readies are gated by reset so nothing looks accepted while held.
        if (res_n) begin
          if (grant_wr) begin
            s_axi.awready = 1'b1;
            s_axi.wready  = 1'b1;
            addr_d        = req_idx;
            wdata_d       = s_axi.wdata;
            wstrb_d       = s_axi.wstrb;
            oor_d         = req_oor;
            last_wr_d     = 1'b1;
            state_d       = WRITE;
          end else if (grant_rd) begin
            s_axi.arready = 1'b1;
            addr_d        = req_idx;
            oor_d         = req_oor;
            last_wr_d     = 1'b0;
            state_d       = READ;
          end
        end
      end
      WRITE: begin
        // wstrb = 0 still strobes the SRAM, just with no byte enables.
        mem_en  = ~oor_q;
        mem_we  = oor_q ? 4'h0 : wstrb_q;
        state_d = WRESP;
      end
      WRESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) state_d = IDLE;
      end
      READ: begin
        mem_en  = ~oor_q;
        state_d = RWAIT;
      end
      RWAIT: begin
        rdata_d = oor_q ? OOR_RDATA : mem_rdata;
        state_d = RDATA;
      end
      RDATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      last_wr_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      last_wr_q <= last_wr_d;
      oor_q     <= oor_d;
    end
  end

endmodule

// File: tb/tb_axi_light_sram_bridge.sv
// Self-checking bench for axi_light_sram_bridge: vector table plus hand-written
// latency, stall, arbitration, range and mid-transaction reset sequences.
// Responses are checked against a queue of expected results.
module tb_axi_light_sram_bridge;
  localparam int unsigned MW = 256;
  localparam int unsigned AW = $clog2(MW);

  logic          clk = 1'b0;
  logic          res_n;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          err;

  if_axi_light axi ();

  axi_light_sram_bridge #(.MEM_WORDS(MW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .res_n(res_n), .s_axi(axi),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM behavioural model: byte writes, read data one cycle after enable.
  logic [31:0] sram [0:MW-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'h0) mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct { bit wr; logic [31:0] data; } exp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [31:0] exp; } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] d);
    exp_t e;
    e.wr = wr; e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (res_n && axi.bvalid && axi.bready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL b_unexpected: got bvalid expected none");
      end else begin
        e = exp_q.pop_front();
        chk("b_order_is_write", 32'(e.wr), 32'h1);
      end
    end
    if (res_n && axi.rvalid && axi.rready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL r_unexpected: got rvalid rdata %h expected none", axi.rdata);
      end else begin
        e = exp_q.pop_front();
        chk("r_order_is_write", 32'(e.wr), 32'h0);
        chk("rdata", axi.rdata, e.data);
      end
    end
  end

  // Drive a write until accepted; returns just after the capture edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!(axi.awready && axi.wready) && n < 64);
    if (!(axi.awready && axi.wready)) begin
      checks++; errors++; $display("FAIL wr_accept_timeout: got no awready/wready expected accept");
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 64);
    if (!axi.arready) begin
      checks++; errors++; $display("FAIL rd_accept_timeout: got no arready expected accept");
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h000, 32'h0F0F_0F0F, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 32'h100, 32'h1122_3344, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 32'h100, 32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h11BB_33DD};
    vecs[4]  = '{1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h203, 32'h1234_5678, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 32'h200, 32'h0,        4'h0, 32'h1234_5678};
    vecs[8]  = '{1'b1, 32'h3FC, 32'h600D_CAFE, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 32'h3FF, 32'h0,        4'h0, 32'h600D_CAFE};
    vecs[10] = '{1'b1, 32'h100, 32'h0102_0304, 4'h8, 32'h0};
    vecs[11] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h01BB_33DD};

    // Reset held with all request valids up.
    res_n = 1'b0;
    axi.awprot = 3'h0; axi.arprot = 3'h0;
    axi.awaddr = 32'h8; axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF; axi.araddr = 32'h8;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(axi.awready), 0);
    chk("rst_wready", 32'(axi.wready), 0);
    chk("rst_arready", 32'(axi.arready), 0);
    chk("rst_bvalid", 32'(axi.bvalid), 0);
    chk("rst_rvalid", 32'(axi.rvalid), 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", 32'(err), 0);
    push(1'b1, 32'h0);
    push(1'b0, 32'h5555_AAAA);
    @(posedge clk); #1 res_n = 1'b1;
    @(negedge clk);
    chk("first_wr_awready", 32'(axi.awready), 1);
    chk("first_wr_wready", 32'(axi.wready), 1);
    chk("first_wr_arready", 32'(axi.arready), 0);
    @(posedge clk); #1 axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 64);
    chk("first_rd_arready", 32'(axi.arready), 1);
    @(posedge clk); #1 axi.arvalid = 1'b0;
    wait_idle();

    // Write latency and b stall (bready low).
    axi.bready = 1'b0;
    push(1'b1, 32'h0);
    wr(32'h100, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("wr_lat_mem_en", 32'(mem_en), 1);
    chk("wr_lat_mem_we", 32'(mem_we), 32'hF);
    chk("wr_lat_mem_addr", 32'(mem_addr), 32'h40);
    chk("wr_lat_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("wr_lat_bvalid_early", 32'(axi.bvalid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wr_stall_bvalid", 32'(axi.bvalid), 1);
      chk("wr_stall_mem_en", 32'(mem_en), 0);
      chk("wr_stall_awready", 32'(axi.awready), 0);
    end
    @(posedge clk); #1 axi.bready = 1'b1;
    wait_idle();

    // Read latency and r stall (rready low).
    axi.rready = 1'b0;
    push(1'b0, 32'hCAFE_F00D);
    rd(32'h100);
    @(negedge clk);
    chk("rd_lat_mem_en", 32'(mem_en), 1);
    chk("rd_lat_mem_we", 32'(mem_we), 0);
    chk("rd_lat_mem_addr", 32'(mem_addr), 32'h40);
    chk("rd_lat_rvalid1", 32'(axi.rvalid), 0);
    @(negedge clk);
    chk("rd_lat_rvalid2", 32'(axi.rvalid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_stall_rvalid", 32'(axi.rvalid), 1);
      chk("rd_stall_rdata", axi.rdata, 32'hCAFE_F00D);
    end
    @(posedge clk); #1 axi.rready = 1'b1;
    wait_idle();

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      push(vecs[i].wr, vecs[i].exp);
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else            rd(vecs[i].addr);
    end
    wait_idle();

    // Both channels pending: last served was a read, so W,R,W,R.
    push(1'b1, 32'h0);
    push(1'b0, 32'hA5A5_0001);
    push(1'b1, 32'h0);
    push(1'b0, 32'hA5A5_0002);
    fork
      begin wr(32'h300, 32'hA5A5_0001, 4'hF); wr(32'h300, 32'hA5A5_0002, 4'hF); end
      begin rd(32'h300); rd(32'h300); end
    join
    wait_idle();

    // Read one past the end of memory.
`ifdef AXI_SRAM_BRIDGE_RANGE_CHECK_EN
    push(1'b0, 32'hDEAD_BEEF);
`else
    push(1'b0, 32'h0F0F_0F0F);
`endif
    axi.araddr = 32'h400; axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 64);
    chk("range_arready", 32'(axi.arready), 1);
`ifdef AXI_SRAM_BRIDGE_RANGE_CHECK_EN
    chk("range_err", 32'(err), 1);
`else
    chk("range_err", 32'(err), 0);
`endif
    @(posedge clk); #1 axi.arvalid = 1'b0;
    @(negedge clk);
`ifdef AXI_SRAM_BRIDGE_RANGE_CHECK_EN
    chk("range_mem_en", 32'(mem_en), 0);
    chk("range_err_after", 32'(err), 0);
    @(negedge clk);
    chk("range_mem_en2", 32'(mem_en), 0);
`else
    chk("range_mem_en", 32'(mem_en), 1);
    chk("range_mem_addr", 32'(mem_addr), 0);
`endif
    wait_idle();

    // Reset while in RWAIT: read is abandoned, next read is normal.
    rd(32'h100);
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(axi.rvalid), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_rdata", axi.rdata, 0);
    @(posedge clk); #1 res_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rvalid", 32'(axi.rvalid), 0);
    end
    push(1'b0, 32'h01BB_33DD);
    rd(32'h100);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
